// File: rtl/analyzer_pkg.sv
// rtl/analyzer_pkg.sv - shared widths and window-control state encoding
package analyzer_pkg;

    localparam int NOTE_W  = 6;
    localparam int WIN_LEN = 16;
    localparam int FEAT_W  = 8;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        STREAM  = 2'd1,
        RELEASE = 2'd2
    } win_state_e;

endpackage

// File: rtl/note_shift_reg.sv
// rtl/note_shift_reg.sv - 16-deep note shift register, oldest note in the low slice
module note_shift_reg
    import analyzer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       shift,
    input  logic [NOTE_W-1:0]          din,
    output logic [WIN_LEN*NOTE_W-1:0]  window
);

    // Newest note enters at the top slice; clear wins over a same-cycle shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window <= '0;
        end else if (clr) begin
            window <= '0;
        end else if (shift) begin
            window <= {din, window[WIN_LEN*NOTE_W-1:NOTE_W]};
        end
    end

endmodule

// File: rtl/note_window_buffer.sv
// rtl/note_window_buffer.sv - sliding 16-note window with hop-paced release handshake
module note_window_buffer
    import analyzer_pkg::*;
#(
    parameter int HOP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [NOTE_W-1:0] note_in,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic                     phrase_clr,
    output logic signed [NOTE_W-1:0] n0,
    output logic signed [NOTE_W-1:0] n1,
    output logic signed [NOTE_W-1:0] n2,
    output logic signed [NOTE_W-1:0] n3,
    output logic signed [NOTE_W-1:0] n4,
    output logic signed [NOTE_W-1:0] n5,
    output logic signed [NOTE_W-1:0] n6,
    output logic signed [NOTE_W-1:0] n7,
    output logic signed [NOTE_W-1:0] n8,
    output logic signed [NOTE_W-1:0] n9,
    output logic signed [NOTE_W-1:0] n10,
    output logic signed [NOTE_W-1:0] n11,
    output logic signed [NOTE_W-1:0] n12,
    output logic signed [NOTE_W-1:0] n13,
    output logic signed [NOTE_W-1:0] n14,
    output logic signed [NOTE_W-1:0] n15,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     feat_valid,
    output logic [15:0]              win_count
);

    generate
        if (HOP < 1 || HOP > WIN_LEN) begin : g_hop_check
            $error("note_window_buffer: HOP must be within 1..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOP_LAST  = CNT_W'(HOP - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIN_LEN - 1);

    win_state_e                 state;
    logic [CNT_W-1:0]           fill_cnt;
    logic [CNT_W-1:0]           hop_cnt;
    logic                       accept;
    logic                       handoff;
    logic [WIN_LEN*NOTE_W-1:0]  window;

    assign accept  = note_valid && note_ready;
    assign handoff = win_valid && win_ready;

    note_shift_reg u_shift (
        .clk    (clk),
        .reset  (reset),
        .clr    (phrase_clr),
        .shift  (accept),
        .din    (note_in),
        .window (window)
    );

    // note_ready and win_valid are registered alongside state so they are
    // always the exact decode of it (ready = not RELEASE, valid = RELEASE).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            fill_cnt   <= '0;
            hop_cnt    <= '0;
            win_valid  <= 1'b0;
            note_ready <= 1'b1;
            win_count  <= '0;
            feat_valid <= 1'b0;
        end else begin
            feat_valid <= handoff && !phrase_clr;
            if (phrase_clr) begin
                state      <= FILL;
                fill_cnt   <= '0;
                hop_cnt    <= '0;
                win_valid  <= 1'b0;
                note_ready <= 1'b1;
            end else begin
                case (state)
                    FILL: begin
                        if (accept) begin
                            fill_cnt <= fill_cnt + 1'b1;
                            if (fill_cnt == FILL_LAST) begin
                                state      <= RELEASE;
                                win_valid  <= 1'b1;
                                note_ready <= 1'b0;
                            end
                        end
                    end
                    STREAM: begin
                        if (accept) begin
                            hop_cnt <= hop_cnt + 1'b1;
                            if (hop_cnt == HOP_LAST) begin
                                state      <= RELEASE;
                                win_valid  <= 1'b1;
                                note_ready <= 1'b0;
                            end
                        end
                    end
                    RELEASE: begin
                        if (win_ready) begin
                            hop_cnt    <= '0;
                            win_count  <= win_count + 16'd1;
                            state      <= STREAM;
                            win_valid  <= 1'b0;
                            note_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= FILL;
                        win_valid  <= 1'b0;
                        note_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign n0  = window[ 0*NOTE_W +: NOTE_W];
    assign n1  = window[ 1*NOTE_W +: NOTE_W];
    assign n2  = window[ 2*NOTE_W +: NOTE_W];
    assign n3  = window[ 3*NOTE_W +: NOTE_W];
    assign n4  = window[ 4*NOTE_W +: NOTE_W];
    assign n5  = window[ 5*NOTE_W +: NOTE_W];
    assign n6  = window[ 6*NOTE_W +: NOTE_W];
    assign n7  = window[ 7*NOTE_W +: NOTE_W];
    assign n8  = window[ 8*NOTE_W +: NOTE_W];
    assign n9  = window[ 9*NOTE_W +: NOTE_W];
    assign n10 = window[10*NOTE_W +: NOTE_W];
    assign n11 = window[11*NOTE_W +: NOTE_W];
    assign n12 = window[12*NOTE_W +: NOTE_W];
    assign n13 = window[13*NOTE_W +: NOTE_W];
    assign n14 = window[14*NOTE_W +: NOTE_W];
    assign n15 = window[15*NOTE_W +: NOTE_W];

endmodule

// File: doc/note_window_buffer.md
# note_window_buffer

Upstream stage of the feature extractor: accepts a serial stream of signed 6-bit note values over a valid/ready handshake. It assembles them into a 16-note sliding window and presents the window in parallel on `n0`..`n15`, with `n0` the oldest note and `n15` the newest. Windows are released every `HOP` accepted notes, under a valid/ready handshake with the analyzer control. A delayed strobe marks the cycle in which the feature extractor's registered outputs correspond to the released window.

## Interface
- `HOP`, default 1: accepted notes between successive windows once the window is full; legal range 1..16.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `note_in`  in  6 (signed)  incoming note value, -32..31.
- `note_valid`  in  1  `note_in` is valid this cycle.
- `note_ready`  out  1  block can accept a note this cycle.
- `phrase_clr`  in  1  single-cycle request to discard the window contents (phrase boundary).
- `n0`..`n15`  out  6 each (signed)  window, `n0` oldest, `n15` newest.
- `win_valid`  out  1  window on `n0`..`n15` is complete and released.
- `win_ready`  in  1  consumer takes the window this cycle.
- `feat_valid`  out  1  feature extractor outputs `f0`..`f15` are valid this cycle.
- `win_count`  out  16  number of windows handed off; wraps at 65535 -> 0.

## Operation
- Accept occurs on `note_valid && note_ready`.
- On accept, the window shifts: `n0<=n1`, ..., `n14<=n15`, `n15<=note_in`.
- `fill_cnt` (0..16) increments on accept and saturates at 16. `hop_cnt` (0..HOP) increments on accept only while `fill_cnt==16`.
- State machine:
  - FILL: `fill_cnt<16`. On the accept that makes `fill_cnt==16`, go to RELEASE.
  - STREAM: window full, waiting for `HOP` more notes. On the accept that makes `hop_cnt==HOP`, go to RELEASE.
  - RELEASE: `win_valid=1` and `note_ready=0`. On `win_ready`, clear `hop_cnt`, increment `win_count`, go to STREAM.
- `note_ready = (state != RELEASE)`. Upstream is back-pressured while a window is pending.
- `n0`..`n15` are stable for every cycle that `win_valid` is high.
- `feat_valid` is a registered copy of `win_valid && win_ready`. It is high exactly one cycle after the handoff, matching the one-register latency of the feature extractor.
- `phrase_clr`:
  - Clears all `n*` to 0, `fill_cnt` and `hop_cnt` to 0, state to FILL, and drops `win_valid`.
  - Takes priority over a same-cycle accept (the note is discarded) and over a same-cycle handoff (no `win_count` increment, no `feat_valid`).
- `win_count` and the `feat_valid` pipeline are not affected by `phrase_clr`.
- No arithmetic on note data. Values pass through unchanged, sign preserved.

## Timing
- Reset (`reset==0`, asynchronous) values:
  - all `n*`, `fill_cnt`, `hop_cnt`, `win_count`: 0
  - state: FILL
  - `note_ready=1`, `win_valid=0`, `feat_valid=0`
- Effects of accept at edge t are visible after edge t. The 16th accept at edge t gives `win_valid=1` from t+1.
- Handoff at edge h (`win_valid && win_ready`) gives `feat_valid=1` during h..h+1, `note_ready=1` from h+1, and `win_count` incremented from h+1.
- `win_ready` high while `win_valid` is low has no effect.
- With `HOP=1`, `win_ready` tied high and `note_valid` continuous, the steady-state rate is one window every 2 cycles.
- Reset asserted mid-RELEASE: outputs go immediately to their reset values. No `feat_valid` is generated.

## Structure
- Shared package `analyzer_pkg` holds:
  - `NOTE_W=6`, `WIN_LEN=16`, `FEAT_W=8`
  - the state enum (FILL, STREAM, RELEASE)
- `HOP` legality is checked at elaboration; elaboration fails if `HOP` is outside 1..16.
- One natural sub-module: `note_shift_reg`, a 16x6 shift register with shift-enable and synchronous clear, driving `n0`..`n15`.
- Control FSM, counters and the `feat_valid` register stay in the top module.

## Test plan
- Fill: after reset, send notes 0..15 with continuous valid -> `win_valid` rises the cycle after the 16th accept; `n0=0`, `n15=15`; `note_ready=0` until handoff.
- Hop, `HOP=4`, `win_ready` tied high: after the first window, send notes 16..19 -> second window has `n0=4`, `n15=19`; `win_count=2`.
- Back-pressure: hold `win_ready=0` for 10 cycles with `note_valid=1` -> `note_ready=0`, window stable, no notes lost. On release, `feat_valid` pulses exactly 1 cycle later.
- Sign extremes: notes alternating -32/31 -> window reproduces the values bit-exact. Downstream `f0` reads 63 and `f1` reads -63.
- `phrase_clr` during RELEASE, coincident with `win_ready`:
  - no `feat_valid`, `win_count` unchanged, all `n*=0`;
  - next 16 notes required before the next `win_valid`.
- Asynchronous reset asserted mid-fill, between clock edges -> all outputs at reset values immediately. Operation resumes cleanly after deassertion.
